// File: rtl/alu64_pkg.sv
// Shared types and constants for the bit-serial 64-bit ALU.
//   op_t    : operation encoding seen on the op port
//   state_t : handshake FSM states
//   DATA_W  : operand / result width
package alu64_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,  // a + b + cin
    OP_SUB = 2'b11   // a + ~b + cin (cin = 1 gives a - b)
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_slice.sv
// Combinational W-bit ALU slice.
//   a, b  : slice operands
//   cin   : carry into the slice LSB
//   op    : operation (alu64_pkg::op_t encoding)
//   s     : slice result
//   cout  : carry out of the slice MSB (0 for AND/OR)
//   c_msb : carry into the slice MSB (0 for AND/OR), for overflow detection
module alu_slice
  import alu64_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [1:0]   op,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  op_t          op_e;
  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves a variable unassigned and no latch is inferred.
    op_e  = op_t'(op);
    b_eff = (op_e == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    s     = sum[W-1:0];
    cout  = 1'b0;
    c_msb = 1'b0;
    unique case (op_e)
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      default: begin
        cout  = sum[W];
        // The MSB sum bit is a ^ b ^ carry_in, so the carry in falls out by XOR.
        c_msb = sum[W-1] ^ a[W-1] ^ b_eff[W-1];
      end
    endcase
  end

endmodule

// File: rtl/alu64_seq.sv
// Bit-serial 64-bit ALU: AND / OR / ADD / SUB computed SLICE_W bits per cycle.
// An operand beat is captured on in_valid && in_ready, then 64/SLICE_W BUSY
// cycles ripple the carry through one shared alu_slice, low slice first. The
// result is presented with out_valid and held until out_ready.
//
// Parameter SLICE_W : bits per cycle, one of 1, 2, 4, 8, 16.
// Macro ALU64_SEQ_FLAGS_EN : adds the zero and ovf result flags.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : operand handshake (ready exactly in IDLE)
//   a, b, cin, op     : operands, carry in, operation
//   out_valid/out_ready : result handshake (valid exactly in DONE)
//   s, cout           : result and final carry (0 for AND/OR)
//   zero, ovf         : result == 0, signed overflow (flags build only)
module alu64_seq
  import alu64_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s,
  output logic        cout
`ifdef ALU64_SEQ_FLAGS_EN
  ,
  output logic        zero,
  output logic        ovf
`endif
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int CNT_W      = $clog2(NUM_SLICES);
  localparam int IDX_W      = $clog2(DATA_W);
  localparam int SH         = $clog2(SLICE_W);

  // Legal slice widths are exactly the divisors of 64 up to 16.
  generate
    if (SLICE_W < 1 || SLICE_W > 16 || (DATA_W % SLICE_W) != 0) begin : g_bad_slice_w
      $error("alu64_seq: SLICE_W must be one of 1, 2, 4, 8, 16");
    end
  endgenerate

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, b_q, s_q, s_d;
  op_t               op_q;
  logic              carry_q;
  logic              cout_q;
  logic [CNT_W-1:0]  k_q;
  logic [IDX_W-1:0]  base;
  logic              accept;
  logic              last_slice;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               slice_c_msb;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_slice = (k_q == CNT_W'(NUM_SLICES - 1));
  assign base       = IDX_W'(k_q) << SH;

  alu_slice #(.W(SLICE_W)) u_slice (
    .a     (a_q[base +: SLICE_W]),
    .b     (b_q[base +: SLICE_W]),
    .cin   (carry_q),
    .op    (op_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  // Result register with the current slice merged in.
  always_comb begin
    s_d                    = s_q;
    s_d[base +: SLICE_W]   = slice_s;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand registers are plain flops, not a memory array, so they
    // take the async reset like everything else; nothing here is left unreset.
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op_t'(op);
      carry_q <= cin;
      k_q     <= '0;
    end else if (state_q == BUSY) begin
      s_q     <= s_d;
      carry_q <= slice_cout;
      k_q     <= k_q + CNT_W'(1);
      // The slice already forces its carry to 0 for AND/OR.
      if (last_slice) cout_q <= slice_cout;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

`ifdef ALU64_SEQ_FLAGS_EN
  logic zero_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == BUSY && last_slice) begin
      zero_q <= (s_d == '0);
      // Carry into bit 63 vs carry out of bit 63; both are 0 for AND/OR.
      ovf_q  <= slice_cout ^ slice_c_msb;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  // Carry into the MSB only feeds the overflow flag.
  logic unused_c_msb;
  assign unused_c_msb = slice_c_msb;
`endif

endmodule

// File: tb/tb_alu64_seq.sv
// Directed bench for alu64_seq. Three instances (SLICE_W = 4, 1, 16) share the
// operand bus and out_ready; each has its own in_valid. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_alu64_seq;
  import alu64_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic        out_ready;
  logic [63:0] a, b;
  logic        cin;
  logic [1:0]  op;

  logic        rdy [3];
  logic        vld [3];
  logic        co  [3];
  logic [63:0] so  [3];
`ifdef ALU64_SEQ_FLAGS_EN
  logic        zo  [3];
  logic        vo  [3];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu64_seq #(.SLICE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(vld[0]), .out_ready(out_ready), .s(so[0]), .cout(co[0])
`ifdef ALU64_SEQ_FLAGS_EN
    , .zero(zo[0]), .ovf(vo[0])
`endif
  );

  alu64_seq #(.SLICE_W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(vld[1]), .out_ready(out_ready), .s(so[1]), .cout(co[1])
`ifdef ALU64_SEQ_FLAGS_EN
    , .zero(zo[1]), .ovf(vo[1])
`endif
  );

  alu64_seq #(.SLICE_W(16)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(vld[2]), .out_ready(out_ready), .s(so[2]), .cout(co[2])
`ifdef ALU64_SEQ_FLAGS_EN
    , .zero(zo[2]), .ovf(vo[2])
`endif
  );

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a, b;
    logic        cin;
    logic [63:0] s;
    logic        c, z, v;
  } vec_t;

  // ------------------------------------------------------------ helpers
  // Wait (bounded) for in_ready, present one beat, drop in_valid after the
  // accepting edge. Returns on the falling edge after acceptance.
  task automatic start_op(input int idx, input logic [1:0] o,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic c);
    for (int n = 0; n < 200 && !rdy[idx]; n++) @(negedge clk);
    op = o; a = av; b = bv; cin = c; iv[idx] = 1'b1;
    @(negedge clk);
    iv[idx] = 1'b0;
  endtask

  // Count falling edges until out_valid; 200 means it never came.
  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (!vld[idx] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0; iv = '0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 2'b00;
    #12;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (rdy[i] !== 1'b1) $display("FAIL reset in_ready[%0d]: got %b want 1", i, rdy[i]); else n_pass++;
      n_checks++; if (vld[i] !== 1'b0) $display("FAIL reset out_valid[%0d]: got %b want 0", i, vld[i]); else n_pass++;
      n_checks++; if (so[i] !== 64'd0) $display("FAIL reset s[%0d]: got %h want 0", i, so[i]); else n_pass++;
      n_checks++; if (co[i] !== 1'b0) $display("FAIL reset cout[%0d]: got %b want 0", i, co[i]); else n_pass++;
`ifdef ALU64_SEQ_FLAGS_EN
      n_checks++; if (zo[i] !== 1'b0) $display("FAIL reset zero[%0d]: got %b want 0", i, zo[i]); else n_pass++;
      n_checks++; if (vo[i] !== 1'b0) $display("FAIL reset ovf[%0d]: got %b want 0", i, vo[i]); else n_pass++;
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t vecs [7];
    int   lat;
    vecs[0] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{OP_SUB, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{OP_OR,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_SUB, 64'd3, 64'd3, 1'b1, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{OP_ADD, 64'd1, 64'd2, 1'b1, 64'd4, 1'b0, 1'b0, 1'b0};
    foreach (vecs[i]) begin
      start_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(0, lat);
      n_checks++; if (lat !== 16) $display("FAIL dir%0d latency: got %0d want 16", i, lat); else n_pass++;
      n_checks++; if (so[0] !== vecs[i].s) $display("FAIL dir%0d s: got %h want %h", i, so[0], vecs[i].s); else n_pass++;
      n_checks++; if (co[0] !== vecs[i].c) $display("FAIL dir%0d cout: got %b want %b", i, co[0], vecs[i].c); else n_pass++;
`ifdef ALU64_SEQ_FLAGS_EN
      n_checks++; if (zo[0] !== vecs[i].z) $display("FAIL dir%0d zero: got %b want %b", i, zo[0], vecs[i].z); else n_pass++;
      n_checks++; if (vo[0] !== vecs[i].v) $display("FAIL dir%0d ovf: got %b want %b", i, vo[0], vecs[i].v); else n_pass++;
`endif
      finish_op();
      n_checks++; if (rdy[0] !== 1'b1 || vld[0] !== 1'b0)
        $display("FAIL dir%0d release: got rdy=%b vld=%b want rdy=1 vld=0", i, rdy[0], vld[0]); else n_pass++;
    end
  endtask

  task automatic test_hold();
    int lat;
    start_op(0, OP_ADD, 64'h10, 64'h20, 1'b0);
    wait_done(0, lat);
    n_checks++; if (lat !== 16) $display("FAIL hold latency: got %0d want 16", lat); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      a = ~a; b = b + 64'd3; op = op + 2'd1; cin = ~cin; iv[0] = 1'b1;
      @(negedge clk);
      n_checks++; if (vld[0] !== 1'b1 || rdy[0] !== 1'b0)
        $display("FAIL hold%0d handshake: got vld=%b rdy=%b want vld=1 rdy=0", c, vld[0], rdy[0]); else n_pass++;
      n_checks++; if (so[0] !== 64'h30 || co[0] !== 1'b0)
        $display("FAIL hold%0d result: got s=%h cout=%b want s=30 cout=0", c, so[0], co[0]); else n_pass++;
    end
    // in_valid stays high across the release edge: no same-cycle accept.
    finish_op();
    iv[0] = 1'b0;
    n_checks++; if (rdy[0] !== 1'b1 || so[0] !== 64'h30)
      $display("FAIL hold no-accept: got rdy=%b s=%h want rdy=1 s=30", rdy[0], so[0]); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int lat;
    int seen;
    start_op(0, OP_ADD, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (rdy[0] !== 1'b1 || vld[0] !== 1'b0)
      $display("FAIL midrst handshake: got rdy=%b vld=%b want rdy=1 vld=0", rdy[0], vld[0]); else n_pass++;
    n_checks++; if (so[0] !== 64'd0 || co[0] !== 1'b0)
      $display("FAIL midrst result: got s=%h cout=%b want s=0 cout=0", so[0], co[0]); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vld[0]) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL midrst stale valid: got %0d cycles want 0", seen); else n_pass++;
    start_op(0, OP_ADD, 64'd3, 64'd4, 1'b0);
    wait_done(0, lat);
    n_checks++; if (lat !== 16) $display("FAIL midrst latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (so[0] !== 64'd7 || co[0] !== 1'b0)
      $display("FAIL midrst next op: got s=%h cout=%b want s=7 cout=0", so[0], co[0]); else n_pass++;
    finish_op();
  endtask

  task automatic test_back_to_back();
    int          lat_exp [3] = '{16, 64, 4};
    int          lat;
    logic [1:0]  o;
    logic [63:0] av, bv, es;
    logic        c, ec, ez, ev;
    logic [64:0] sum;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 5; n++) begin
        o  = 2'(n + d);
        av = {$urandom, $urandom};
        bv = (n == 4) ? ~av : {$urandom, $urandom};
        c  = 1'($urandom);
        // Reference: one full-width 65-bit add.
        sum = {1'b0, av} + {1'b0, (o == OP_SUB) ? ~bv : bv} + {64'd0, c};
        case (o)
          OP_AND:  begin es = av & bv; ec = 1'b0; end
          OP_OR:   begin es = av | bv; ec = 1'b0; end
          default: begin es = sum[63:0]; ec = sum[64]; end
        endcase
        ez = (es == 64'd0);
        ev = (o == OP_ADD || o == OP_SUB) &&
             (av[63] == ((o == OP_SUB) ? ~bv[63] : bv[63])) && (es[63] != av[63]);
        start_op(d, o, av, bv, c);
        wait_done(d, lat);
        n_checks++; if (lat !== lat_exp[d]) $display("FAIL b2b d%0d n%0d latency: got %0d want %0d", d, n, lat, lat_exp[d]); else n_pass++;
        n_checks++; if (so[d] !== es) $display("FAIL b2b d%0d n%0d s: got %h want %h", d, n, so[d], es); else n_pass++;
        n_checks++; if (co[d] !== ec) $display("FAIL b2b d%0d n%0d cout: got %b want %b", d, n, co[d], ec); else n_pass++;
`ifdef ALU64_SEQ_FLAGS_EN
        n_checks++; if (zo[d] !== ez) $display("FAIL b2b d%0d n%0d zero: got %b want %b", d, n, zo[d], ez); else n_pass++;
        n_checks++; if (vo[d] !== ev) $display("FAIL b2b d%0d n%0d ovf: got %b want %b", d, n, vo[d], ev); else n_pass++;
`else
        if (ez && ev) lat = 0;  // flags unused in this build
`endif
        finish_op();
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
